// File: rtl/pll_lock_divider_if.sv
// Control and status bundle for pll_lock_divider: enable, reference tick,
// expected period and divide values in; divided clocks, lock status and period out.
interface pll_lock_divider_if #(
  parameter int NUM_OUT   = 4,
  parameter int DIV_WIDTH = 8,
  parameter int CNT_WIDTH = 12
);
  logic                           PLL_EN;
  logic                           REF_TICK;
  logic [CNT_WIDTH-1:0]           EXP_COUNT;
  logic [NUM_OUT*DIV_WIDTH-1:0]   DIV;
  logic [NUM_OUT-1:0]             CLK_OUT;
  logic                           LOCK;
  logic                           LOCK_LOST;
  logic [CNT_WIDTH-1:0]           PERIOD;

  modport master (
    output PLL_EN, REF_TICK, EXP_COUNT, DIV,
    input  CLK_OUT, LOCK, LOCK_LOST, PERIOD
  );

  modport slave (
    input  PLL_EN, REF_TICK, EXP_COUNT, DIV,
    output CLK_OUT, LOCK, LOCK_LOST, PERIOD
  );
endinterface

// File: rtl/pll_lock_divider.sv
// PLL output stage: reference-period measurement, lock acquisition/loss FSM and
// NUM_OUT phase-aligned programmable clock dividers that run only while locked.
module pll_lock_divider #(
  parameter int NUM_OUT    = 4,
  parameter int DIV_WIDTH  = 8,
  parameter int CNT_WIDTH  = 12,
  parameter int LOCK_TIMER = 16,
  parameter int TOL        = 2
) (
  input logic                CLK,
  input logic                RESET,
  pll_lock_divider_if.slave  bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_ACQ    = 2'd2;
  localparam logic [1:0] ST_LOCKED = 2'd3;

  localparam int GW = $clog2(LOCK_TIMER + 1);
  localparam logic [GW-1:0]          GOOD_LAST = GW'(LOCK_TIMER - 1);
  localparam logic [CNT_WIDTH-1:0]   CNT_MAX   = '1;
  localparam logic [CNT_WIDTH-1:0]   CNT_PRE   = {{(CNT_WIDTH-1){1'b1}}, 1'b0};
  localparam logic [CNT_WIDTH-1:0]   CNT_ONE   = CNT_WIDTH'(1);
  localparam logic signed [CNT_WIDTH:0] TOL_S  = (CNT_WIDTH+1)'(TOL);

  // Deviation is taken one bit wider than the counter so it can never wrap.
  function automatic logic in_tol(input logic [CNT_WIDTH-1:0] n,
                                  input logic [CNT_WIDTH-1:0] e);
    logic signed [CNT_WIDTH:0] dev;
    dev = $signed({1'b0, n}) - $signed({1'b0, e});
    if (dev < 0) dev = -dev;
    return dev <= TOL_S;
  endfunction

  function automatic logic [DIV_WIDTH-1:0] clamp_div(input logic [DIV_WIDTH-1:0] d);
    return (d < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : d;
  endfunction

  function automatic logic [DIV_WIDTH-1:0] half_hi(input logic [DIV_WIDTH-1:0] d);
    return (d >> 1) + {{(DIV_WIDTH-1){1'b0}}, d[0]};
  endfunction

  logic [1:0]           state;
  logic [CNT_WIDTH-1:0] per_cnt;
  logic [GW-1:0]        good_cnt;
  logic [CNT_WIDTH-1:0] period_q;
  logic                 lock_q;
  logic                 lost_q;
  logic [NUM_OUT-1:0]   clk_out_w;

  logic measuring, tick_meas, sat_evt, good, bad_evt, lock_enter, lock_drop;

  assign measuring  = bus.PLL_EN && ((state == ST_ACQ) || (state == ST_LOCKED));
  assign tick_meas  = measuring && bus.REF_TICK;
  assign sat_evt    = measuring && !bus.REF_TICK && (per_cnt == CNT_PRE);
  assign good       = in_tol(per_cnt, bus.EXP_COUNT);
  assign bad_evt    = (tick_meas && !good) || sat_evt;
  assign lock_enter = (state == ST_ACQ) && tick_meas && good && (good_cnt == GOOD_LAST);
  assign lock_drop  = (state == ST_LOCKED) && bad_evt;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= ST_IDLE;
      per_cnt  <= '0;
      good_cnt <= '0;
      period_q <= '0;
      lock_q   <= 1'b0;
      lost_q   <= 1'b0;
    end else if (!bus.PLL_EN) begin
      state    <= ST_IDLE;
      per_cnt  <= '0;
      good_cnt <= '0;
      period_q <= '0;
      lock_q   <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      lost_q <= lock_drop;
      case (state)
        ST_IDLE: state <= ST_WAIT;
        ST_WAIT: begin
          if (bus.REF_TICK) begin
            state   <= ST_ACQ;
            per_cnt <= CNT_ONE;
          end
        end
        default: begin
          // Every tick closes one measurement and opens the next.
          if (bus.REF_TICK) begin
            period_q <= per_cnt;
            per_cnt  <= CNT_ONE;
          end else if (per_cnt != CNT_MAX) begin
            per_cnt <= per_cnt + CNT_ONE;
          end
          if (bad_evt || lock_enter)
            good_cnt <= '0;
          else if (bus.REF_TICK && (state == ST_ACQ))
            good_cnt <= good_cnt + GW'(1);
          if (lock_enter) begin
            state  <= ST_LOCKED;
            lock_q <= 1'b1;
          end else if (lock_drop) begin
            state  <= ST_ACQ;
            lock_q <= 1'b0;
          end
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_ch
    logic [DIV_WIDTH-1:0] ch_d, ch_c, ch_new;
    logic                 ch_out;

    assign ch_new = clamp_div(bus.DIV[g*DIV_WIDTH +: DIV_WIDTH]);

    // Shadow divide value only changes at a wrap, so periods are never cut short.
    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
        ch_d   <= '0;
        ch_c   <= '0;
        ch_out <= 1'b0;
      end else if (lock_enter) begin
        ch_d   <= ch_new;
        ch_c   <= '0;
        ch_out <= 1'b1;
      end else if (bus.PLL_EN && (state == ST_LOCKED) && !lock_drop) begin
        if (ch_c == ch_d - 1'b1) begin
          ch_d   <= ch_new;
          ch_c   <= '0;
          ch_out <= 1'b1;
        end else begin
          ch_c   <= ch_c + 1'b1;
          ch_out <= (ch_c + 1'b1) < half_hi(ch_d);
        end
      end else begin
        ch_c   <= '0;
        ch_out <= 1'b0;
      end
    end

    assign clk_out_w[g] = ch_out;
  end

  assign bus.CLK_OUT   = clk_out_w;
  assign bus.LOCK      = lock_q;
  assign bus.LOCK_LOST = lost_q;
  assign bus.PERIOD    = period_q;

endmodule

// File: tb/tb_pll_lock_divider.sv
// Directed bench for pll_lock_divider: expectations are queued per clock edge
// as stimulus is driven and checked against the DUT at the following falling edge.
module tb_pll_lock_divider;

  localparam int NO = 4;
  localparam int DW = 8;
  localparam int CW = 8;
  localparam int LT = 16;
  localparam int TL = 2;

  localparam int S_LOCK = 0;
  localparam int S_LOST = 1;
  localparam int S_PER  = 2;
  localparam int S_CLK  = 3;

  typedef struct {
    string       tag;
    int          e;
    int          sig;
    logic [31:0] val;
  } exp_t;

  logic        CLK   = 1'b0;
  logic        RESET = 1'b1;
  int          edge_n = 0;
  int          checks = 0;
  int          fails  = 0;
  int          mi;
  int          lk_edge;
  logic [31:0] got;
  exp_t        sb[$];

  pll_lock_divider_if #(.NUM_OUT(NO), .DIV_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  pll_lock_divider #(
    .NUM_OUT(NO), .DIV_WIDTH(DW), .CNT_WIDTH(CW), .LOCK_TIMER(LT), .TOL(TL)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) edge_n <= edge_n + 1;

  function automatic logic [31:0] obs(input int s);
    case (s)
      S_LOCK:  return 32'(bus.LOCK);
      S_LOST:  return 32'(bus.LOCK_LOST);
      S_PER:   return 32'(bus.PERIOD);
      default: return 32'(bus.CLK_OUT);
    endcase
  endfunction

  function automatic void push(input string t, input int e, input int s, input logic [31:0] v);
    exp_t x;
    x.tag = t; x.e = e; x.sig = s; x.val = v;
    sb.push_back(x);
  endfunction

  initial forever begin
    @(negedge CLK);
    mi = 0;
    while (mi < sb.size()) begin
      if (sb[mi].e == edge_n) begin
        got = obs(sb[mi].sig);
        checks++;
        assert (got === sb[mi].val) else begin
          fails++;
          $error("FAIL %s edge=%0d observed=%0h expected=%0h", sb[mi].tag, edge_n, got, sb[mi].val);
        end
        sb.delete(mi);
      end else begin
        mi++;
      end
    end
  end

  task automatic cyc_drive(input logic tick);
    bus.REF_TICK = tick;
    @(posedge CLK);
    #1;
    bus.REF_TICK = 1'b0;
  endtask

  task automatic gap_tick(input int sp);
    repeat (sp - 1) cyc_drive(1'b0);
    cyc_drive(1'b1);
  endtask

  task automatic tick_chk(input int sp, input logic lk_pre, input logic lk,
                          input logic lost, input int per);
    push("lock_pre", edge_n + sp - 1, S_LOCK, 32'(lk_pre));
    push("lock",     edge_n + sp,     S_LOCK, 32'(lk));
    push("lost",     edge_n + sp,     S_LOST, 32'(lost));
    push("period",   edge_n + sp,     S_PER,  32'(per));
    gap_tick(sp);
  endtask

  task automatic good_run(input int n, input int spa, input int spb, input bit lock_end);
    for (int i = 1; i <= n; i++) begin
      int sp;
      sp = (i % 2 == 1) ? spa : spb;
      tick_chk(sp, 1'b0, lock_end && (i == n), 1'b0, sp);
    end
  endtask

  initial begin
    bus.PLL_EN    = 1'b0;
    bus.REF_TICK  = 1'b0;
    bus.EXP_COUNT = 8'd100;
    bus.DIV       = {8'd2, 8'd3, 8'd4, 8'd5};
    RESET         = 1'b1;

    repeat (2) cyc_drive(1'b0);
    push("rst_lock",   edge_n, S_LOCK, 0);
    push("rst_lost",   edge_n, S_LOST, 0);
    push("rst_period", edge_n, S_PER,  0);
    push("rst_clk",    edge_n, S_CLK,  0);
    cyc_drive(1'b0);
    RESET = 1'b0;
    cyc_drive(1'b0);

    // First acquisition at a steady 100-cycle reference.
    bus.PLL_EN = 1'b1;
    cyc_drive(1'b0);
    cyc_drive(1'b0);
    cyc_drive(1'b1);
    push("wait_period", edge_n, S_PER, 0);
    good_run(LT, 100, 100, 1'b1);

    // Divider outputs from the lock edge, with ch0 reprogrammed 5 -> 6 mid-period.
    lk_edge = edge_n;
    for (int k = 0; k < 50; k++) begin
      int v;
      v = 0;
      for (int c = 0; c < NO; c++) begin
        int p, r;
        p = 5 - c;
        r = k;
        if (c == 0 && k >= 35) begin
          p = 6;
          r = k - 35;
        end
        if ((r % p) < (p + 1) / 2) v = v | (1 << c);
      end
      push("clk_out", lk_edge + k, S_CLK, 32'(v));
    end
    repeat (32) cyc_drive(1'b0);
    bus.DIV[7:0] = 8'd6;
    repeat (18) cyc_drive(1'b0);
    tick_chk(50, 1'b1, 1'b1, 1'b0, 100);

    // Single out-of-tolerance period while locked, then re-acquire.
    push("drop_clk", edge_n + 103, S_CLK, 0);
    tick_chk(103, 1'b1, 1'b0, 1'b1, 103);
    push("lost_end", edge_n + 1, S_LOST, 0);
    good_run(LT, 100, 100, 1'b1);

    // Enable falls on the same cycle as a reference tick.
    repeat (10) cyc_drive(1'b0);
    bus.PLL_EN = 1'b0;
    push("en_lock",   edge_n + 1, S_LOCK, 0);
    push("en_lost",   edge_n + 1, S_LOST, 0);
    push("en_period", edge_n + 1, S_PER,  0);
    push("en_clk",    edge_n + 1, S_CLK,  0);
    push("en_lost2",  edge_n + 2, S_LOST, 0);
    cyc_drive(1'b1);
    cyc_drive(1'b0);

    // Edge-of-window spacings 98/102 still acquire lock.
    bus.PLL_EN = 1'b1;
    cyc_drive(1'b0);
    cyc_drive(1'b1);
    push("wait_period2", edge_n, S_PER, 0);
    good_run(LT, 98, 102, 1'b1);

    // A 97-cycle period during acquisition restarts the good count.
    bus.PLL_EN = 1'b0;
    cyc_drive(1'b0);
    bus.PLL_EN = 1'b1;
    cyc_drive(1'b0);
    cyc_drive(1'b1);
    good_run(5, 100, 100, 1'b0);
    tick_chk(97, 1'b0, 1'b0, 1'b0, 97);
    good_run(LT, 100, 100, 1'b1);

    // Reference stops while locked: one loss at counter saturation only.
    lk_edge = edge_n;
    push("sat_lock_pre", lk_edge + 253, S_LOCK, 1);
    push("sat_lock",     lk_edge + 254, S_LOCK, 0);
    push("sat_lost",     lk_edge + 254, S_LOST, 1);
    push("sat_lost_end", lk_edge + 255, S_LOST, 0);
    push("sat_quiet",    lk_edge + 300, S_LOST, 0);
    push("sat_period",   lk_edge + 300, S_PER,  100);
    push("sat_clk",      lk_edge + 300, S_CLK,  0);
    repeat (409) cyc_drive(1'b0);
    cyc_drive(1'b1);
    push("sat_tick_period", edge_n, S_PER,  255);
    push("sat_tick_lost",   edge_n, S_LOST, 0);
    good_run(LT, 100, 100, 1'b1);

    // Asynchronous reset mid-lock, then restart from idle.
    repeat (3) cyc_drive(1'b0);
    #1;
    RESET = 1'b1;
    push("arst_lock",   edge_n, S_LOCK, 0);
    push("arst_lost",   edge_n, S_LOST, 0);
    push("arst_period", edge_n, S_PER,  0);
    push("arst_clk",    edge_n, S_CLK,  0);
    cyc_drive(1'b0);
    push("arst_lost2", edge_n, S_LOST, 0);
    RESET = 1'b0;
    cyc_drive(1'b0);
    cyc_drive(1'b1);
    push("restart_wait_period", edge_n, S_PER, 0);
    tick_chk(100, 1'b0, 1'b0, 1'b0, 100);
    repeat (3) cyc_drive(1'b0);

    checks++;
    assert (sb.size() == 0) else begin
      fails++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/pll_lock_divider.md
# pll_lock_divider

Parametrised, synthesizable PLL output stage for the VCO clock domain. It measures the spacing of reference-clock ticks against an expected VCO-cycle count, runs a lock-acquisition state machine with a tolerance window and loss-of-lock detection, and drives NUM_OUT phase-aligned, runtime-programmable divided clock outputs once locked. It replaces the fixed DIV2/DIV3/DIV4 taps and the free-running lock timer of the previous PLL generation.

## Interface
- NUM_OUT, 4: number of divided output channels (1-16)
- DIV_WIDTH, 8: width of each channel divide value
- CNT_WIDTH, 12: width of the period counter and EXP_COUNT
- LOCK_TIMER, 16: consecutive in-tolerance periods required to lock (>=1)
- TOL, 2: allowed absolute deviation of a measured period from EXP_COUNT, in CLK cycles

- CLK  input  1  VCO clock; all logic on rising edge
- RESET  input  1  asynchronous, active-high reset
- PLL_EN  input  1  enable; low forces IDLE synchronously
- REF_TICK  input  1  one-cycle pulse per reference period, already synchronised to CLK
- EXP_COUNT  input  CNT_WIDTH  expected CLK cycles per reference period
- DIV  input  NUM_OUT*DIV_WIDTH  channel i divide value at [i*DIV_WIDTH +: DIV_WIDTH]
- CLK_OUT  output  NUM_OUT  registered divided clocks
- LOCK  output  1  registered lock indication
- LOCK_LOST  output  1  one-cycle pulse on loss of lock
- PERIOD  output  CNT_WIDTH  last measured reference period in CLK cycles

## Operation
- Reset values: state IDLE, CLK_OUT=0, LOCK=0, LOCK_LOST=0, PERIOD=0, all counters 0.
- Measured period N = cycles between two consecutive REF_TICK assertions (ticks at cycles t and t+N). Period counter saturates at 2^CNT_WIDTH-1; saturation counts as one bad period (handled once, at the saturating cycle), and the counter stays saturated until the next tick.
- Good period: |N - EXP_COUNT| <= TOL, computed at CNT_WIDTH+1 bits, no wrap.
- States:
  - IDLE: outputs 0. PLL_EN=1 -> WAIT_TICK.
  - WAIT_TICK: the first REF_TICK starts the period counter -> ACQUIRE. There is no PERIOD update on this tick.
  - ACQUIRE: on each tick, PERIOD<=N. A good period increments good_cnt; a bad period clears it. When good_cnt reaches LOCK_TIMER -> LOCKED.
  - LOCKED: on each tick, PERIOD<=N. A bad period (or saturation) pulses LOCK_LOST for one cycle and goes to ACQUIRE with good_cnt=0. The tick that ended the bad period starts the next measurement.
- PLL_EN=0 in any state -> IDLE on the next edge. LOCK, CLK_OUT and the counters are cleared and LOCK_LOST is not pulsed.
- Dividers run only while LOCK=1. Each channel has a shadow divide value d (DIV value < 2 treated as 2) and a count c that runs 0..d-1 and then wraps.
  - CLK_OUT[i]=1 for c < ceil(d/2), else 0. Duty is exactly 50% for even d; for odd d the high phase is one cycle longer.
  - Shadow d loads from DIV on entry to LOCKED and at each wrap (c=d-1). A mid-period DIV change never shortens or glitches the current period.
- On LOCKED entry, all channel counts are 0, so all CLK_OUT rise together.

## Timing
- LOCK rises on the edge after the qualifying tick, i.e. the LOCK_TIMER-th consecutive good tick after the WAIT_TICK tick. All CLK_OUT rise on that same edge.
- LOCK falls and LOCK_LOST pulses on the edge after the bad tick, in the same cycle. CLK_OUT goes to 0 on that same edge.
- PERIOD updates one edge after each measuring tick.
- REF_TICK coincident with PLL_EN falling: PLL_EN wins and the block goes to IDLE.
- RESET asserted mid-operation clears all outputs immediately. After RESET releases, the block restarts from IDLE.

## Test plan
- EXP_COUNT=100, ticks every 100 cycles, LOCK_TIMER=16 -> LOCK rises 1 cycle after the 17th tick. PERIOD=100. LOCK_LOST never asserts.
- Locked, then one tick at spacing 103 (TOL=2) -> LOCK_LOST pulses 1 cycle and LOCK drops. After 16 more good ticks, LOCK re-asserts.
- Spacings 98 and 102 interleaved -> lock is acquired. Spacing 97 during ACQUIRE -> good_cnt restarts and lock is delayed by 16 more ticks.
- DIV={5,4,3,2} after lock -> CLK_OUT periods 5/4/3/2 with high phases 3/2/2/1, rising together on the lock edge. Changing ch0 from 5 to 6 mid-period -> the old period completes, then the 6-cycle period starts.
- Ticks stop while locked, CNT_WIDTH=8 -> LOCK_LOST when the counter saturates at 255, and no further pulses. Deasserting PLL_EN or asserting RESET mid-lock -> LOCK, CLK_OUT and PERIOD follow their defined values with no LOCK_LOST pulse.
